// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Arbitrates ROB flushes and frontend redirects into PC
//               selects. Frontend redirects are suppressed for a short
//               window after each ROB flush, and the PC is held while the
//               core waits in idle.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
  parameter int SHADOW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rob_mispredict,
  input  logic        rob_excp,
  input  logic        rob_ertn,
  input  logic        rob_idle,
  input  logic        intr_pending,
  input  logic        icache_ready,
  input  logic        fq_full,
  input  logic        pre_jump,
  input  logic        pre_miss,
  input  logic        bpu_predict,
  output logic        flush_pc_branch,
  output logic        flush_pc_excp,
  output logic        flush_pc_ertn,
  output logic        flush_pc_idle,
  output logic        jump_ok,
  output logic        miss_ok,
  output logic        predict_ok,
  output logic        stall_pc,
  output logic        flush_backend,
  output logic        halted,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_SHADOW = 2'd1;
  localparam logic [1:0] c_ST_IDLE   = 2'd2;
  localparam logic [2:0] c_SHADOW_LD = 3'(SHADOW);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [2:0]  r_shadow_cnt;
  logic [2:0]  w_next_cnt;
  logic        r_flush_bk;
  logic [31:0] r_flush_cnt;

  logic        w_in_idle;
  logic        w_sel_br;
  logic        w_sel_ex;
  logic        w_sel_er;
  logic        w_sel_id;
  logic        w_flush;

  // Priority select of at most one ROB flush; rst gates everything so
  // nothing escapes while reset is held, and idle is ignored when already idle.
  always_comb begin
    w_in_idle = (r_state == c_ST_IDLE);
    w_sel_br  = rst & rob_mispredict;
    w_sel_ex  = rst & ~rob_mispredict & rob_excp;
    w_sel_er  = rst & ~rob_mispredict & ~rob_excp & rob_ertn;
    w_sel_id  = rst & ~rob_mispredict & ~rob_excp & ~rob_ertn & rob_idle & ~w_in_idle;
    w_flush   = w_sel_br | w_sel_ex | w_sel_er | w_sel_id;
  end

  // State, shadow counter, trailing backend flush and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_ST_RUN;
      r_shadow_cnt <= 3'd0;
      r_flush_bk   <= 1'b0;
      r_flush_cnt  <= 32'd0;
    end else begin
      r_state      <= w_next_state;
      r_shadow_cnt <= w_next_cnt;
      r_flush_bk   <= w_flush;
      if (w_flush) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  // Next-state logic: any non-idle flush (re)arms the suppression window.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_shadow_cnt;
    case (r_state)
      c_ST_RUN: begin
        if (w_sel_id) begin
          w_next_state = c_ST_IDLE;
          w_next_cnt   = 3'd0;
        end else if (w_flush) begin
          w_next_state = c_ST_SHADOW;
          w_next_cnt   = c_SHADOW_LD;
        end
      end
      c_ST_SHADOW: begin
        if (w_sel_id) begin
          w_next_state = c_ST_IDLE;
          w_next_cnt   = 3'd0;
        end else if (w_flush) begin
          w_next_cnt   = c_SHADOW_LD;
        end else if (r_shadow_cnt <= 3'd1) begin
          w_next_state = c_ST_RUN;
          w_next_cnt   = 3'd0;
        end else begin
          w_next_cnt   = r_shadow_cnt - 3'd1;
        end
      end
      c_ST_IDLE: begin
        if (w_flush || intr_pending) begin
          w_next_state = c_ST_SHADOW;
          w_next_cnt   = c_SHADOW_LD;
        end
      end
      default: begin
        w_next_state = c_ST_RUN;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  // Output logic: one-hot PC selects, gated frontend redirects and stall.
  always_comb begin
    flush_pc_branch = w_sel_br;
    flush_pc_excp   = w_sel_ex;
    flush_pc_ertn   = w_sel_er;
    flush_pc_idle   = w_sel_id;
    jump_ok         = 1'b0;
    miss_ok         = 1'b0;
    predict_ok      = 1'b0;
    if (rst && (r_state == c_ST_RUN) && !w_flush) begin
      jump_ok    = pre_jump;
      miss_ok    = ~pre_jump & pre_miss;
      predict_ok = ~pre_jump & ~pre_miss & bpu_predict;
    end
    stall_pc      = ~w_flush & (w_in_idle | ~icache_ready | fq_full);
    flush_backend = w_flush | r_flush_bk;
    halted        = w_in_idle;
    flush_cnt     = r_flush_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_ctrl
// Description : Directed-vector bench; stimulus pushes expected outputs into
//               a queue and a monitor pops and compares them each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rob_mispredict = 1'b0;
  logic        rob_excp = 1'b0;
  logic        rob_ertn = 1'b0;
  logic        rob_idle = 1'b0;
  logic        intr_pending = 1'b0;
  logic        icache_ready = 1'b1;
  logic        fq_full = 1'b0;
  logic        pre_jump = 1'b0;
  logic        pre_miss = 1'b0;
  logic        bpu_predict = 1'b0;
  logic        flush_pc_branch;
  logic        flush_pc_excp;
  logic        flush_pc_ertn;
  logic        flush_pc_idle;
  logic        jump_ok;
  logic        miss_ok;
  logic        predict_ok;
  logic        stall_pc;
  logic        flush_backend;
  logic        halted;
  logic [31:0] flush_cnt;

  typedef struct {
    logic [9:0]  exp_o;
    logic [31:0] exp_cnt;
    string       name;
  } exp_t;

  exp_t q_exp[$];
  int   r_vectors = 0;
  int   r_miscompares = 0;

  pc_redirect_ctrl #(.SHADOW(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .rob_mispredict  (rob_mispredict),
    .rob_excp        (rob_excp),
    .rob_ertn        (rob_ertn),
    .rob_idle        (rob_idle),
    .intr_pending    (intr_pending),
    .icache_ready    (icache_ready),
    .fq_full         (fq_full),
    .pre_jump        (pre_jump),
    .pre_miss        (pre_miss),
    .bpu_predict     (bpu_predict),
    .flush_pc_branch (flush_pc_branch),
    .flush_pc_excp   (flush_pc_excp),
    .flush_pc_ertn   (flush_pc_ertn),
    .flush_pc_idle   (flush_pc_idle),
    .jump_ok         (jump_ok),
    .miss_ok         (miss_ok),
    .predict_ok      (predict_ok),
    .stall_pc        (stall_pc),
    .flush_backend   (flush_backend),
    .halted          (halted),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Inputs {rst, mis, excp, ertn, idle, intr, icache_ready, fq_full, pj, pm, bp}
  // Expected {br, ex, er, id, jump_ok, miss_ok, predict_ok, stall, flush_bk, halted}
  task automatic step(input logic [10:0] v, input logic [9:0] e,
                      input logic [31:0] ec, input string nm, input bit pre = 1'b0);
    exp_t t;
    @(posedge clk);
    #1;
    if (pre) begin
      force dut.r_flush_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_flush_cnt;
    end
    {rst, rob_mispredict, rob_excp, rob_ertn, rob_idle, intr_pending,
     icache_ready, fq_full, pre_jump, pre_miss, bpu_predict} = v;
    t.exp_o   = e;
    t.exp_cnt = ec;
    t.name    = nm;
    q_exp.push_back(t);
  endtask

  // Monitor: every cycle the DUT presents a response, compare it to the queue head.
  initial begin
    exp_t t;
    logic [9:0] obs;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        t   = q_exp.pop_front();
        obs = {flush_pc_branch, flush_pc_excp, flush_pc_ertn, flush_pc_idle,
               jump_ok, miss_ok, predict_ok, stall_pc, flush_backend, halted};
        r_vectors++;
        if (obs !== t.exp_o) begin
          r_miscompares++;
          $display("FAIL %s outputs: got %b expected %b", t.name, obs, t.exp_o);
        end
        r_vectors++;
        if (flush_cnt !== t.exp_cnt) begin
          r_miscompares++;
          $display("FAIL %s flush_cnt: got %h expected %h", t.name, flush_cnt, t.exp_cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    step(11'b0_1100_0_10_100, 10'b0000_000_000, 32'd0, "reset_gates_outputs");
    step(11'b1_0000_0_10_000, 10'b0000_000_000, 32'd0, "run_quiet");
    step(11'b1_0000_0_10_111, 10'b0000_100_000, 32'd0, "prio_jump");
    step(11'b1_0000_0_10_011, 10'b0000_010_000, 32'd0, "prio_miss");
    step(11'b1_0000_0_10_001, 10'b0000_001_000, 32'd0, "predict_only");
    step(11'b1_0000_0_00_100, 10'b0000_100_100, 32'd0, "icache_not_ready");
    step(11'b1_0000_0_11_000, 10'b0000_000_100, 32'd0, "fq_full");
    step(11'b1_1100_0_00_100, 10'b1000_000_010, 32'd0, "mis_over_excp");
    step(11'b1_0000_0_10_100, 10'b0000_000_010, 32'd1, "shadow_c1");
    step(11'b1_0000_0_10_100, 10'b0000_000_000, 32'd1, "shadow_c2");
    step(11'b1_0000_0_10_100, 10'b0000_100_000, 32'd1, "run_c3_jump");
    step(11'b1_0100_0_10_000, 10'b0100_000_010, 32'd1, "excp_flush");
    step(11'b1_0010_0_10_000, 10'b0010_000_010, 32'd2, "ertn_in_shadow");
    step(11'b1_0000_0_10_100, 10'b0000_000_010, 32'd3, "shadow_reloaded");
    step(11'b1_0001_0_10_000, 10'b0001_000_010, 32'd3, "idle_from_shadow");
    step(11'b1_0000_0_10_100, 10'b0000_000_111, 32'd4, "idle_wait_enter");
    step(11'b1_0001_0_10_000, 10'b0000_000_101, 32'd4, "idle_ignored");
    step(11'b1_0000_1_10_000, 10'b0000_000_101, 32'd4, "intr_exit");
    step(11'b1_0000_0_10_100, 10'b0000_000_000, 32'd4, "post_intr_s1");
    step(11'b1_0000_0_10_100, 10'b0000_000_000, 32'd4, "post_intr_s2");
    step(11'b1_0000_0_10_100, 10'b0000_100_000, 32'd4, "post_intr_run");
    step(11'b1_0001_0_10_000, 10'b0001_000_010, 32'd4, "idle_again");
    step(11'b1_0100_1_10_000, 10'b0100_000_011, 32'd5, "intr_and_excp");
    step(11'b1_0000_0_10_000, 10'b0000_000_010, 32'd6, "fb_trail");
    step(11'b1_0000_0_10_000, 10'b0000_000_000, 32'd6, "shadow_end");
    step(11'b1_0001_0_10_000, 10'b0001_000_010, 32'd6, "idle_third");
    step(11'b0_0000_0_10_010, 10'b0000_000_000, 32'd0, "reset_in_idle");
    step(11'b1_0000_0_10_010, 10'b0000_010_000, 32'd0, "miss_after_reset");
    step(11'b1_0010_0_10_000, 10'b0010_000_010, 32'hFFFF_FFFF, "ertn_at_max", 1'b1);
    step(11'b1_0000_0_10_000, 10'b0000_000_010, 32'd0, "cnt_wrap");
    step(11'b0_0000_0_10_100, 10'b0000_000_000, 32'd0, "reset_in_shadow");
    step(11'b1_0000_0_10_100, 10'b0000_100_000, 32'd0, "no_residual_shadow");
    @(posedge clk);
    #1;
    {rst, rob_mispredict, rob_excp, rob_ertn, rob_idle, intr_pending,
     icache_ready, fq_full, pre_jump, pre_miss, bpu_predict} = 11'b1_0000_0_10_000;
    @(negedge clk);
    #1;
    r_vectors++;
    if (q_exp.size() != 0) begin
      r_miscompares++;
      $display("FAIL drain: %0d responses left, expected 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
